// File: rtl/ibex_dummy_reseed_ctrl_if.sv
// Entropy request/acknowledge handshake between the reseed controller and the entropy source.
interface ibex_dummy_reseed_ctrl_if;
  logic        entropy_req;
  logic        entropy_ack;
  logic [31:0] entropy_data;

  modport master (
    output entropy_req,
    input  entropy_ack,
    input  entropy_data
  );

  modport slave (
    input  entropy_req,
    output entropy_ack,
    output entropy_data
  );
endinterface

// File: rtl/ibex_dummy_reseed_ctrl.sv
// Reseed sequencer for the dummy-instruction LFSR: counts accepted dummy instructions, fetches
// entropy every reseed_interval_i insertions and arbitrates the seed strobe against CSR writes.
module ibex_dummy_reseed_ctrl #(
  parameter int unsigned CntW       = 16,
  parameter int unsigned AckTimeout = 255
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         dummy_instr_en_i,
  input  logic [CntW-1:0]              reseed_interval_i,
  input  logic                         insert_dummy_instr_i,
  input  logic                         id_in_ready_i,
  input  logic                         csr_seed_wr_i,
  input  logic [31:0]                  csr_seed_i,
  ibex_dummy_reseed_ctrl_if.master     entropy_if,
  output logic                         dummy_instr_en_o,
  output logic                         dummy_seed_en_o,
  output logic [31:0]                  dummy_seed_o,
  output logic                         reseed_busy_o,
  output logic                         reseed_timeout_o
);

  localparam int unsigned TmoW = (AckTimeout > 1) ? $clog2(AckTimeout) : 1;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StSeed = 2'b10
  } state_e;

  state_e            state_r;
  logic [CntW-1:0]   cnt_r;
  logic [TmoW-1:0]   tmo_cnt_r;
  logic [31:0]       entropy_q_r;
  logic              timeout_r;

  logic              accept_s;
  logic [CntW:0]     cnt_inc_s;
  logic              threshold_s;
  logic              cnt_sat_s;
  logic              tmo_last_s;

  // Accept/threshold decode; the widened increment keeps the compare free of wrap-around.
  always_comb begin
    accept_s    = insert_dummy_instr_i & id_in_ready_i & dummy_instr_en_i;
    cnt_inc_s   = {1'b0, cnt_r} + {{CntW{1'b0}}, 1'b1};
    threshold_s = (reseed_interval_i != {CntW{1'b0}}) &&
                  (cnt_inc_s >= {1'b0, reseed_interval_i});
    cnt_sat_s   = &cnt_r;
    tmo_last_s  = (tmo_cnt_r == TmoW'(AckTimeout - 1));
  end

  // Reseed FSM, insertion counter, handshake timeout and captured entropy word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= StIdle;
      cnt_r       <= {CntW{1'b0}};
      tmo_cnt_r   <= {TmoW{1'b0}};
      entropy_q_r <= 32'h0000_0000;
      timeout_r   <= 1'b0;
    end else begin
      timeout_r <= 1'b0;
      case (state_r)
        StIdle: begin
          if (csr_seed_wr_i) begin
            cnt_r <= {CntW{1'b0}};
          end else if (accept_s && threshold_s) begin
            cnt_r     <= {CntW{1'b0}};
            tmo_cnt_r <= {TmoW{1'b0}};
            state_r   <= StReq;
          end else if (accept_s && !cnt_sat_s) begin
            cnt_r <= cnt_inc_s[CntW-1:0];
          end else begin
            cnt_r <= cnt_r;
          end
        end
        StReq: begin
          // A CSR write aborts the handshake; an ack in the same cycle is consumed and dropped.
          if (csr_seed_wr_i) begin
            cnt_r   <= {CntW{1'b0}};
            state_r <= StIdle;
          end else if (entropy_if.entropy_ack) begin
            entropy_q_r <= entropy_if.entropy_data;
            state_r     <= StSeed;
          end else if (tmo_last_s) begin
            timeout_r <= 1'b1;
            state_r   <= StIdle;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + {{(TmoW-1){1'b0}}, 1'b1};
          end
        end
        StSeed: begin
          cnt_r   <= {CntW{1'b0}};
          state_r <= StIdle;
        end
        default: begin
          cnt_r   <= {CntW{1'b0}};
          state_r <= StIdle;
        end
      endcase
    end
  end

  // Seed strobe mux: a CSR write passes straight through and overrides the entropy seed.
  always_comb begin
    if (!rst_ni) begin
      dummy_seed_en_o = 1'b0;
      dummy_seed_o    = 32'h0000_0000;
    end else if (csr_seed_wr_i) begin
      dummy_seed_en_o = 1'b1;
      dummy_seed_o    = csr_seed_i;
    end else if (state_r == StSeed) begin
      dummy_seed_en_o = 1'b1;
      dummy_seed_o    = entropy_q_r;
    end else begin
      dummy_seed_en_o = 1'b0;
      dummy_seed_o    = 32'h0000_0000;
    end
  end

  assign entropy_if.entropy_req = (state_r == StReq);
  assign dummy_instr_en_o       = rst_ni & dummy_instr_en_i & (state_r == StIdle);
  assign reseed_busy_o          = (state_r != StIdle);
  // The timeout pulse yields to a coincident CSR seed strobe.
  assign reseed_timeout_o       = timeout_r & ~csr_seed_wr_i;

endmodule

// File: tb/tb_ibex_dummy_reseed_ctrl.sv
// Scoreboard bench for ibex_dummy_reseed_ctrl: stimulus queues expected events stamped with their
// cycle, a negedge monitor pops and compares each request edge, seed strobe and timeout pulse.
module tb_ibex_dummy_reseed_ctrl;
  localparam int EV_RISE = 0;
  localparam int EV_FALL = 1;
  localparam int EV_SEED = 2;
  localparam int EV_TMO  = 3;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        en_i;
  logic [15:0] interval;
  logic        ins;
  logic        rdy;
  logic        csr_wr;
  logic [31:0] csr_seed;
  logic        en_o;
  logic        seed_en;
  logic [31:0] seed;
  logic        busy;
  logic        tmo;

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc          = 0;
  logic req_prev     = 1'b0;
  exp_t exp_q[$];
  int   b;

  ibex_dummy_reseed_ctrl_if eif ();

  ibex_dummy_reseed_ctrl #(.CntW(16), .AckTimeout(8)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_ni),
    .dummy_instr_en_i    (en_i),
    .reseed_interval_i   (interval),
    .insert_dummy_instr_i(ins),
    .id_in_ready_i       (rdy),
    .csr_seed_wr_i       (csr_wr),
    .csr_seed_i          (csr_seed),
    .entropy_if          (eif),
    .dummy_instr_en_o    (en_o),
    .dummy_seed_en_o     (seed_en),
    .dummy_seed_o        (seed),
    .reseed_busy_o       (busy),
    .reseed_timeout_o    (tmo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int at, input logic [31:0] data);
    exp_t e;
    e.kind = kind;
    e.cyc  = at;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic mon_event(input int kind, input logic [31:0] data);
    exp_t e;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL unexpected_event: got kind %0d data %h at cycle %0d, none expected", kind, data, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.data !== data) begin
        tests_failed++;
        $display("FAIL event: got kind %0d cycle %0d data %h expected kind %0d cycle %0d data %h",
                 kind, cyc, data, e.kind, e.cyc, e.data);
      end
    end
  endtask

  // Monitor: every observable event is matched against the head of the scoreboard queue.
  always @(negedge clk) begin
    if (eif.entropy_req && !req_prev) mon_event(EV_RISE, 32'h0);
    if (!eif.entropy_req && req_prev) mon_event(EV_FALL, 32'h0);
    if (seed_en) mon_event(EV_SEED, seed);
    if (tmo) mon_event(EV_TMO, 32'h0);
    req_prev <= eif.entropy_req;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},     {31'h0, eif.entropy_req}, 32'h0);
    check({tag, "_seed_en"}, {31'h0, seed_en},         32'h0);
    check({tag, "_seed"},    seed,                     32'h0);
    check({tag, "_en_o"},    {31'h0, en_o},            32'h0);
    check({tag, "_busy"},    {31'h0, busy},            32'h0);
    check({tag, "_tmo"},     {31'h0, tmo},             32'h0);
  endtask

  initial begin
    rst_ni           = 1'b0;
    en_i             = 1'b1;
    interval         = 16'd4;
    ins              = 1'b0;
    rdy              = 1'b1;
    csr_wr           = 1'b0;
    csr_seed         = 32'h0;
    eif.entropy_ack  = 1'b0;
    eif.entropy_data = 32'h0;
    #2;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    step();
    check("idle_en_o", {31'h0, en_o}, 32'h1);

    // 1: four accepts at interval 4, then an entropy handshake.
    b   = cyc;
    ins = 1'b1;
    push_ev(EV_RISE, b + 4, 32'h0);
    push_ev(EV_FALL, b + 7, 32'h0);
    push_ev(EV_SEED, b + 7, 32'hDEAD_BEEF);
    repeat (4) step();
    ins = 1'b0;
    check("t1_en_o_gated", {31'h0, en_o}, 32'h0);
    check("t1_busy",       {31'h0, busy}, 32'h1);
    step();
    step();
    eif.entropy_ack  = 1'b1;
    eif.entropy_data = 32'hDEAD_BEEF;
    step();
    eif.entropy_ack  = 1'b0;
    step();
    check("t1_en_o_back", {31'h0, en_o}, 32'h1);
    check("t1_busy_idle", {31'h0, busy}, 32'h0);

    // 2: interval 0 disables auto reseed; a stray ack in IDLE is ignored.
    interval = 16'd0;
    ins      = 1'b1;
    repeat (1000) step();
    ins = 1'b0;
    eif.entropy_ack  = 1'b1;
    eif.entropy_data = 32'hBAD0_BAD0;
    step();
    eif.entropy_ack  = 1'b0;
    step();
    check("t2_busy", {31'h0, busy}, 32'h0);

    // 3: lowering the interval below the count triggers at once; no ack -> timeout after 8 cycles.
    b        = cyc;
    interval = 16'd1;
    ins      = 1'b1;
    push_ev(EV_RISE, b + 1, 32'h0);
    push_ev(EV_FALL, b + 9, 32'h0);
    push_ev(EV_TMO,  b + 9, 32'h0);
    step();
    ins = 1'b0;
    repeat (8) step();
    check("t3_busy", {31'h0, busy}, 32'h0);
    step();
    step();

    // 4: CSR write and ack together in REQ; the CSR seed wins and no SEED cycle follows.
    b   = cyc;
    ins = 1'b1;
    push_ev(EV_RISE, b + 1, 32'h0);
    push_ev(EV_SEED, b + 2, 32'h1234_5678);
    push_ev(EV_FALL, b + 3, 32'h0);
    step();
    ins = 1'b0;
    step();
    csr_wr           = 1'b1;
    csr_seed         = 32'h1234_5678;
    eif.entropy_ack  = 1'b1;
    eif.entropy_data = 32'hAAAA_5555;
    step();
    csr_wr          = 1'b0;
    eif.entropy_ack = 1'b0;
    check("t4_busy", {31'h0, busy}, 32'h0);
    step();
    step();

    // 5: interval 3, CSR write coincides with the threshold accept and clears the count.
    b        = cyc;
    interval = 16'd3;
    ins      = 1'b1;
    push_ev(EV_SEED, b + 2, 32'h0BAD_F00D);
    push_ev(EV_RISE, b + 6, 32'h0);
    push_ev(EV_FALL, b + 7, 32'h0);
    push_ev(EV_SEED, b + 7, 32'hCAFE_F00D);
    step();
    step();
    csr_wr   = 1'b1;
    csr_seed = 32'h0BAD_F00D;
    step();
    csr_wr = 1'b0;
    check("t5_no_req", {31'h0, busy}, 32'h0);
    step();
    step();
    step();
    ins = 1'b0;
    check("t5_busy", {31'h0, busy}, 32'h1);
    eif.entropy_ack  = 1'b1;
    eif.entropy_data = 32'hCAFE_F00D;
    step();
    eif.entropy_ack = 1'b0;
    step();
    check("t5_en_o", {31'h0, en_o}, 32'h1);

    // 6a: reset asserted while in REQ.
    b        = cyc;
    interval = 16'd1;
    ins      = 1'b1;
    push_ev(EV_RISE, b + 1, 32'h0);
    push_ev(EV_FALL, b + 2, 32'h0);
    step();
    ins = 1'b0;
    step();
    rst_ni = 1'b0;
    #1;
    check_all_zero("t6_req");
    step();
    rst_ni = 1'b1;
    step();
    check("t6a_busy", {31'h0, busy}, 32'h0);
    check("t6a_en_o", {31'h0, en_o}, 32'h1);

    // 6b: reset asserted while in SEED; the entropy seed is never strobed.
    b   = cyc;
    ins = 1'b1;
    push_ev(EV_RISE, b + 1, 32'h0);
    push_ev(EV_FALL, b + 2, 32'h0);
    step();
    ins              = 1'b0;
    eif.entropy_ack  = 1'b1;
    eif.entropy_data = 32'h55AA_55AA;
    step();
    eif.entropy_ack = 1'b0;
    rst_ni          = 1'b0;
    #1;
    check_all_zero("t6_seed");
    step();
    rst_ni = 1'b1;
    step();
    check("t6b_busy", {31'h0, busy}, 32'h0);
    check("t6b_en_o", {31'h0, en_o}, 32'h1);

    repeat (4) step();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
